// File: rtl/bus_wait_state_ctrl.sv
// 6502 phase-2 clock generator with per-region wait-state stretching and a
// bounded wait on an external ready line; VIA clock runs free at clk/2.
module bus_wait_state_ctrl #(
  parameter int         WAIT0_DEF   = 3,
  parameter int         WAIT1_DEF   = 0,
  parameter int         WAIT2_DEF   = 1,
  parameter int         WAIT3_DEF   = 0,
  parameter logic [3:0] RDY_MASK    = 4'b0001,
  parameter int         RDY_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adr_hi,
  input  logic [7:0] adr_lo,
  input  logic       rw,
  input  logic [7:0] dat_bus,
  input  logic       rdy,
  output logic       sys_clk,
  output logic       via_clk,
  output logic       stretch_active,
  output logic       wait_timeout
);

  // state | meaning
  // LOW   | sys_clk low, exactly one clk
  // HIGH  | first clk of the sys_clk high phase
  // WAIT  | counting configured wait states
  // RDYW  | holding the high phase until rdy or timeout
  typedef enum logic [1:0] {LOW, HIGH, WAIT, RDYW} stateT;

  stateT      state;
  logic [3:0] cfg [4];
  logic [3:0] waitCnt;
  logic [7:0] rdyCnt;
  logic       hit;
  logic [1:0] region;

  logic       decHit;
  logic [1:0] decRegion;
  logic       cfgWr;
  logic       rdyNeed;
  logic       rdyAtLimit;
  logic       leaveHigh;
  logic       timeoutHit;
  logic       unusedDat;

  assign unusedDat  = ^dat_bus[5:4];
  assign cfgWr      = ({adr_hi, adr_lo} == 16'h0002) && !rw;
  assign rdyNeed    = hit && RDY_MASK[region];
  assign rdyAtLimit = (rdyCnt == 8'(RDY_TIMEOUT - 1));

  always_comb begin
    decHit    = 1'b1;
    decRegion = 2'd0;
    if (adr_hi == 8'h9F && adr_lo[7:1] == 7'b0100_000)
      decRegion = 2'd0;
    else if (adr_hi == 8'h9F && adr_lo[7:5] == 3'b000)
      decRegion = 2'd1;
    else if (adr_hi == 8'h9F && adr_lo[7:4] == 4'h6)
      decRegion = 2'd2;
    else if (adr_hi[7:6] == 2'b11)
      decRegion = 2'd3;
    else
      decHit = 1'b0;
  end

  always_comb begin
    leaveHigh  = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      HIGH, WAIT: leaveHigh = (waitCnt == 4'd0) && !(rdyNeed && !rdy);
      RDYW: begin
        leaveHigh  = rdy || rdyAtLimit;
        timeoutHit = !rdy && rdyAtLimit;
      end
      default: leaveHigh = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= LOW;
      sys_clk        <= 1'b0;
      via_clk        <= 1'b0;
      stretch_active <= 1'b0;
      wait_timeout   <= 1'b0;
      waitCnt        <= 4'd0;
      rdyCnt         <= 8'd0;
      hit            <= 1'b0;
      region         <= 2'd0;
      cfg[0]         <= 4'(WAIT0_DEF);
      cfg[1]         <= 4'(WAIT1_DEF);
      cfg[2]         <= 4'(WAIT2_DEF);
      cfg[3]         <= 4'(WAIT3_DEF);
    end else begin
      via_clk <= ~via_clk;
      case (state)
        LOW: begin
          state          <= HIGH;
          sys_clk        <= 1'b1;
          stretch_active <= 1'b0;
          hit            <= decHit;
          region         <= decRegion;
          waitCnt        <= decHit ? cfg[decRegion] : 4'd0;
        end
        HIGH, WAIT: begin
          if (waitCnt != 4'd0) begin
            state          <= WAIT;
            waitCnt        <= waitCnt - 4'd1;
            stretch_active <= 1'b1;
          end else if (rdyNeed && !rdy) begin
            state          <= RDYW;
            rdyCnt         <= 8'd0;
            stretch_active <= 1'b1;
          end
        end
        RDYW: begin
          if (!rdy && !rdyAtLimit)
            rdyCnt <= rdyCnt + 8'd1;
        end
        default: state <= LOW;
      endcase

      // Every exit from the high phase funnels through here, so the config
      // write and the timeout flag share one place.
      if (leaveHigh) begin
        state          <= LOW;
        sys_clk        <= 1'b0;
        stretch_active <= 1'b0;
        if (cfgWr) begin
          cfg[dat_bus[7:6]] <= dat_bus[3:0];
          wait_timeout      <= 1'b0;
        end
        if (timeoutHit)
          wait_timeout <= 1'b1;
      end
    end
  end

endmodule
